if_id_skid: RTL and testbench

Parametrised IF/ID pipeline boundary with valid/ready handshaking on both sides and a two-entry skid buffer, so neither side's stall signal travels combinationally across the boundary. It sits between instruction fetch and decode and replaces the plain stall/flush register. It adds a configurable sideband field, occupancy reporting and a saturating stall-cycle counter. Invalid or flushed slots present a canonical NOP to decode.

---
 rtl/if_id_skid_if.sv | 27 ++
 rtl/if_id_skid.sv | 110 +++++++++++
 tb/tb_if_id_skid.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/if_id_skid_if.sv
// IF/ID boundary handshake bundle: fetch-side offer, decode-side presentation, flush.
interface if_id_skid_if #(
  parameter int XLEN   = 32,
  parameter int SIDE_W = 4
);
  logic              up_valid;
  logic              up_ready;
  logic [XLEN-1:0]   up_pc;
  logic [XLEN-1:0]   up_instr;
  logic [SIDE_W-1:0] up_side;
  logic              flush;
  logic              dn_valid;
  logic              dn_ready;
  logic [XLEN-1:0]   dn_pc;
  logic [XLEN-1:0]   dn_instr;
  logic [SIDE_W-1:0] dn_side;

  modport slave (
    input  up_valid, up_pc, up_instr, up_side, flush, dn_ready,
    output up_ready, dn_valid, dn_pc, dn_instr, dn_side
  );

  modport master (
    output up_valid, up_pc, up_instr, up_side, flush, dn_ready,
    input  up_ready, dn_valid, dn_pc, dn_instr, dn_side
  );
endinterface

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with a two-entry skid buffer; all outputs come straight
// from flops so neither stall signal crosses the boundary combinationally.
module if_id_skid #(
  parameter int              XLEN      = 32,
  parameter int              SIDE_W    = 4,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013),
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  if_id_skid_if.slave      bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   instr;
    logic [SIDE_W-1:0] side;
  } entry_t;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  localparam entry_t NOP_E = '{pc: '0, instr: NOP_INSTR, side: '0};

  state_t           state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  logic [CNT_W-1:0] stall_cnt_q;
  entry_t           up_e;
  logic             up_xfer;

  assign up_e    = '{pc: bus.up_pc, instr: bus.up_instr, side: bus.up_side};
  assign up_xfer = bus.up_valid && (state_q != FULL);

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (up_xfer) begin
          state_d = ONE;
          main_d  = up_e;
        end
      end
      ONE: begin
        if (bus.dn_ready) begin
          if (up_xfer) begin
            main_d = up_e;
          end else begin
            state_d = EMPTY;
            main_d  = NOP_E;
          end
        end else if (up_xfer) begin
          state_d = FULL;
          skid_d  = up_e;
        end
      end
      FULL: begin
        if (bus.dn_ready) begin
          state_d = ONE;
          main_d  = skid_q;
          skid_d  = NOP_E;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = NOP_E;
        skid_d  = NOP_E;
      end
    endcase
    // Flush wins over everything; an entry consumed this cycle is still gone.
    if (bus.flush) begin
      state_d = EMPTY;
      main_d  = NOP_E;
      skid_d  = NOP_E;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= NOP_E;
      skid_q  <= NOP_E;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (bus.dn_valid && !bus.dn_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.up_ready = (state_q != FULL);
  assign bus.dn_valid = (state_q != EMPTY);
  assign bus.dn_pc    = main_q.pc;
  assign bus.dn_instr = main_q.instr;
  assign bus.dn_side  = main_q.side;
  assign occupancy    = state_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_if_id_skid.sv
// Randomized + directed bench: a count/queue reference model feeds a scoreboard
// that a separate monitor drains whenever decode takes an entry.
module tb_if_id_skid;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        up_valid = 1'b0, flush = 1'b0, dn_ready = 1'b0;
  logic [31:0] up_pc = '0, up_instr = '0;
  logic [3:0]  up_side = '0;
  logic [1:0]  occ, occ2;
  logic [15:0] stall;
  logic [1:0]  stall2;

  always #5 clk = ~clk;

  if_id_skid_if #(.XLEN(32), .SIDE_W(4)) bus ();
  if_id_skid_if #(.XLEN(32), .SIDE_W(4)) b2 ();

  assign bus.up_valid = up_valid;
  assign bus.up_pc    = up_pc;
  assign bus.up_instr = up_instr;
  assign bus.up_side  = up_side;
  assign bus.flush    = flush;
  assign bus.dn_ready = dn_ready;
  assign b2.up_valid  = up_valid;
  assign b2.up_pc     = up_pc;
  assign b2.up_instr  = up_instr;
  assign b2.up_side   = up_side;
  assign b2.flush     = flush;
  assign b2.dn_ready  = dn_ready;

  if_id_skid #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .occupancy(occ), .stall_cnt(stall)
  );

  // Narrow-counter copy fed the same stimulus, used for saturation.
  if_id_skid #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(b2.slave), .occupancy(occ2), .stall_cnt(stall2)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  side;
  } ent_t;

  ent_t sb[$];
  int   occ_m   = 0;
  int   stall_m = 0;
  int   n_chk   = 0;
  int   n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: the stage is a FIFO of depth 2; only counts and a queue.
  always @(posedge clk or posedge rst) begin : model
    bit ux, dx;
    if (rst) begin
      occ_m   = 0;
      stall_m = 0;
      sb.delete();
    end else begin
      ux = up_valid && (occ_m < 2);
      dx = (occ_m > 0) && dn_ready;
      if ((occ_m > 0) && !dn_ready && (stall_m < 65535)) stall_m++;
      if (flush) begin
        occ_m = 0;
        sb.delete();
      end else begin
        occ_m = occ_m + int'(ux) - int'(dx);
        if (ux) sb.push_back('{pc: up_pc, instr: up_instr, side: up_side});
      end
    end
  end

  // Monitor: late in each cycle, after inputs settle and before the next edge.
  always @(negedge clk) begin : monitor
    ent_t e;
    #4;
    chk("dn_valid",  {31'b0, bus.dn_valid}, {31'b0, occ_m > 0});
    chk("up_ready",  {31'b0, bus.up_ready}, {31'b0, occ_m < 2});
    chk("occupancy", {30'b0, occ},  32'(occ_m));
    chk("occ_narrow", {30'b0, occ2}, 32'(occ_m));
    chk("stall_cnt", {16'b0, stall}, 32'(stall_m));
    chk("stall_sat", {30'b0, stall2}, (stall_m > 3) ? 32'd3 : 32'(stall_m));
    if (!bus.dn_valid) begin
      chk("idle_pc",    bus.dn_pc,    32'h0);
      chk("idle_instr", bus.dn_instr, NOP);
      chk("idle_side",  {28'b0, bus.dn_side}, 32'h0);
    end else if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL unexpected_entry: got pc %h expected no valid entry", bus.dn_pc);
    end else begin
      e = sb[0];
      chk("dn_pc",    bus.dn_pc,    e.pc);
      chk("dn_instr", bus.dn_instr, e.instr);
      chk("dn_side",  {28'b0, bus.dn_side}, {28'b0, e.side});
      if (dn_ready && !rst) void'(sb.pop_front());
    end
  end

  task automatic cyc(input bit v, input logic [31:0] pc, input bit r, input bit f,
                     output bit acc);
    @(negedge clk);
    #2;
    up_valid = v;
    up_pc    = pc;
    up_instr = $urandom;
    up_side  = 4'($urandom);
    dn_ready = r;
    flush    = f;
    acc      = v && bus.up_ready;
  endtask

  task automatic send(input logic [31:0] pc, input bit r);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      cyc(1'b1, pc, r, 1'b0, acc);
      n++;
    end
    if (!acc) begin
      n_chk++;
      $display("FAIL send_timeout: got no acceptance of pc %h required acceptance within 20 cycles", pc);
    end
  endtask

  initial begin : driver
    bit acc;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) cyc(1'b0, 32'h0, 1'b1, 1'b0, acc);

    // Streaming with decode always ready.
    send(32'h100, 1'b1);
    send(32'h104, 1'b1);
    send(32'h108, 1'b1);
    repeat (2) cyc(1'b0, 32'h0, 1'b1, 1'b0, acc);

    // Back-pressure: third entry must wait in IF until the skid drains.
    cyc(1'b1, 32'h200, 1'b0, 1'b0, acc);
    cyc(1'b1, 32'h204, 1'b0, 1'b0, acc);
    repeat (3) cyc(1'b1, 32'h208, 1'b0, 1'b0, acc);
    send(32'h208, 1'b1);
    repeat (3) cyc(1'b0, 32'h0, 1'b1, 1'b0, acc);

    // Flush while full, with a concurrent offer that must be dropped.
    cyc(1'b1, 32'h2a0, 1'b0, 1'b0, acc);
    cyc(1'b1, 32'h2a4, 1'b0, 1'b0, acc);
    cyc(1'b1, 32'h300, 1'b0, 1'b1, acc);
    repeat (3) cyc(1'b0, 32'h0, 1'b1, 1'b0, acc);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), $urandom & 32'hffff_fffc,
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), acc);

    // Async reset while full, checked before the next edge.
    repeat (2) cyc(1'b0, 32'h0, 1'b1, 1'b0, acc);
    cyc(1'b1, 32'h400, 1'b0, 1'b0, acc);
    cyc(1'b1, 32'h404, 1'b0, 1'b0, acc);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, acc);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_dn_valid",  {31'b0, bus.dn_valid}, 32'h0);
    chk("rst_dn_pc",     bus.dn_pc, 32'h0);
    chk("rst_dn_instr",  bus.dn_instr, NOP);
    chk("rst_dn_side",   {28'b0, bus.dn_side}, 32'h0);
    chk("rst_up_ready",  {31'b0, bus.up_ready}, 32'h1);
    chk("rst_occupancy", {30'b0, occ}, 32'h0);
    chk("rst_stall_cnt", {16'b0, stall}, 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    send(32'h500, 1'b1);
    repeat (3) cyc(1'b0, 32'h0, 1'b1, 1'b0, acc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
